// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment scan driver with
// double-buffered display data, anti-ghost blanking and leading-zero suppression.
module seg_scan_driver #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              blank_lz,
    output logic [3:0]        hex,
    output logic [NDIG-1:0]   an,
    output logic              dp,
    output logic              pending,
    output logic              frame_tick
);
    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] shadow, disp;
    logic [NDIG-1:0]   shadow_dp, disp_dp;
    logic              wrap, boundary, zeros_above, cur_dp, cur_dark, lit;
    logic [3:0]        cur_hex;
    logic [NDIG-1:0]   an_next;
    assign wrap     = presc == PW'(DIV - 1);
    assign boundary = wrap && idx == IW'(NDIG - 1);
    // Walk from the most significant digit down so zeros_above covers digits k..NDIG-1.
    always_comb begin
        cur_hex     = 4'h0;
        cur_dp      = 1'b0;
        cur_dark    = 1'b0;
        zeros_above = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zeros_above = zeros_above && disp[4*k +: 4] == 4'h0;
            if (IW'(k) == idx) begin
                cur_hex  = disp[4*k +: 4];
                cur_dp   = disp_dp[k];
                cur_dark = blank_lz && k != 0 && !disp_dp[k] && zeros_above;
            end
        end
        lit     = presc >= PW'(BLANK) && !cur_dark;
        an_next = ~(NDIG'(lit) << idx);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) idx <= idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
        end
    end
    // A load on the boundary cycle lands in the shadow after the old shadow moves out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            shadow_dp <= '0;
            disp      <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
        end else begin
            if (boundary && pending) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
            end
            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end
            pending <= load || (pending && !boundary);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex        <= 4'h0;
            an         <= '1;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hex        <= cur_hex;
            an         <= an_next;
            dp         <= cur_dp;
            frame_tick <= boundary;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed plus randomized checks of seg_scan_driver against
// a cycle-count based reference model.
module tb_seg_scan_driver;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp, pending, frame_tick;
    int          vectors = 0;
    int          miscompares = 0;
    int          n = 0;
    logic        blz = 1'b0;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_dp, m_shdp;
    logic        m_pend;

    seg_scan_driver #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .hex(hex), .an(an), .dp(dp), .pending(pending),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_disp = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_pend = 1'b0;
    endtask

    // Cycle n after reset release sits in slot n/DIV at phase n%DIV; outputs lag by one clock.
    task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d);
        int p, dg;
        logic bnd, dark;
        logic [3:0] exp_an, exp_hex;
        load = ld; value = v; dp_in = d; blank_lz = blz;
        @(posedge clk);
        #1;
        p       = n % DIV;
        dg      = (n / DIV) % NDIG;
        bnd     = p == DIV - 1 && dg == NDIG - 1;
        dark    = blz && dg != 0 && !m_dp[dg] && (m_disp >> (4 * dg)) == 0;
        exp_an  = (p < BLANK || dark) ? 4'hF : 4'(~(1 << dg));
        exp_hex = 4'(m_disp >> (4 * dg));
        chk("an", an, exp_an);
        chk("hex", hex, exp_hex);
        chk("dp", dp, m_dp[dg]);
        chk("frame_tick", frame_tick, bnd);
        chk("an_onehot", $countones(~an) <= 1, 1);
        if (bnd && m_pend) begin
            m_disp = m_sh;
            m_dp   = m_shdp;
        end
        if (ld) begin
            m_sh   = v;
            m_shdp = d;
        end
        m_pend = ld || (m_pend && !bnd);
        chk("pending", pending, m_pend);
        n++;
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) tick(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic run_to(input int phase);
        while (n % FRAME != phase) tick(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_hex"}, hex, 4'h0);
        chk({tag, "_dp"}, dp, 1'b0);
        chk({tag, "_pending"}, pending, 1'b0);
        chk({tag, "_frame_tick"}, frame_tick, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(FRAME + 8);
        run_to(10);
        tick(1'b1, 16'h12AB, 4'h0);
        idle(2 * FRAME);
        blz = 1'b1;
        tick(1'b1, 16'h0050, 4'h0);
        idle(2 * FRAME);
        tick(1'b1, 16'h0050, 4'b0100);
        idle(2 * FRAME);
        run_to(5);
        tick(1'b1, 16'h1111, 4'h0);
        idle(6);
        tick(1'b1, 16'h2222, 4'h0);
        idle(2 * FRAME);
        run_to(FRAME - 1);
        tick(1'b1, 16'h3333, 4'b1000);
        idle(2 * FRAME);
        blz = 1'b0;
        tick(1'b1, 16'h0007, 4'h0);
        idle(2 * FRAME);
        run_to(2 * DIV + 4);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(FRAME + 4);
        for (int i = 0; i < 800; i++) begin
            if (i % 37 == 0) blz = 1'($urandom);
            tick($urandom_range(0, 15) == 0, 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
                 $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
